branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver.sv | 187 ++++++++++++++++++
 tb/tb_branch_resolver.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
//
// In-order queue of predicted branches. Fetch pushes each predicted branch
// together with its fetch-time history snapshot. Execute resolves branches
// strictly in order; each resolve pops the head entry. When the actual outcome
// differs from the prediction, a registered redirect pulse is raised and the
// whole queue is discarded.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   push_valid/push_ready   fetch handshake
//   push_pc, push_pred_taken, push_pred_target, push_hist   predicted branch
//   res_valid/res_ready     execute handshake
//   res_pc, res_taken, res_target                           resolved branch
//   brinfo[33:0]            predictor update, packed {valid, pc[31:0], taken}
//   brinfo_hist             fetch-time history of the entry in brinfo
//   flush_valid, flush_pc   one-cycle redirect pulse and redirect address
//   order_err               sticky flag: a resolve did not match the head pc
//   stat_resolved, stat_mispred   saturating statistics counters
//
// Configuration
//   BRANCH_RESOLVER_STATS_EN  when defined, builds the statistics counters;
//                             otherwise both stat ports are tied to zero.
// -----------------------------------------------------------------------------
module branch_resolver #(
    parameter int DEPTH      = 8,
    parameter int WIDTH_HIST = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [31:0]           push_pc,
    input  logic                  push_pred_taken,
    input  logic [31:0]           push_pred_target,
    input  logic [WIDTH_HIST-1:0] push_hist,
    input  logic                  res_valid,
    output logic                  res_ready,
    input  logic [31:0]           res_pc,
    input  logic                  res_taken,
    input  logic [31:0]           res_target,
    output logic [33:0]           brinfo,
    output logic [WIDTH_HIST-1:0] brinfo_hist,
    output logic                  flush_valid,
    output logic [31:0]           flush_pc,
    output logic                  order_err,
    output logic [31:0]           stat_resolved,
    output logic [31:0]           stat_mispred
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Entry storage; contents need no reset because count gates every read.
    logic [31:0]           pc_mem_r   [DEPTH];
    logic [31:0]           tgt_mem_r  [DEPTH];
    logic [WIDTH_HIST-1:0] hist_mem_r [DEPTH];
    logic [DEPTH-1:0]      taken_mem_r;

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;

    logic                  brinfo_valid_r;
    logic [31:0]           brinfo_pc_r;
    logic                  brinfo_taken_r;
    logic [WIDTH_HIST-1:0] brinfo_hist_r;
    logic                  flush_valid_r;
    logic [31:0]           flush_pc_r;
    logic                  order_err_r;

    logic                  push_fire_s;
    logic                  res_fire_s;
    logic                  mispred_s;
    logic [31:0]           head_pc_s;
    logic                  head_taken_s;
    logic [31:0]           head_tgt_s;
    logic [WIDTH_HIST-1:0] head_hist_s;
    logic [31:0]           flush_tgt_s;

    // Pushes are blocked during the redirect cycle so fetch restarts cleanly.
    assign push_ready  = (count_r < CNT_W'(DEPTH)) & ~flush_valid_r;
    assign res_ready   = (count_r != {CNT_W{1'b0}});
    assign push_fire_s = push_valid & push_ready;
    assign res_fire_s  = res_valid & res_ready;

    assign head_pc_s    = pc_mem_r[rd_ptr_r];
    assign head_taken_s = taken_mem_r[rd_ptr_r];
    assign head_tgt_s   = tgt_mem_r[rd_ptr_r];
    assign head_hist_s  = hist_mem_r[rd_ptr_r];

    // A taken branch is only correct if both direction and target match.
    assign mispred_s   = res_fire_s & ((res_taken != head_taken_s) |
                                       (res_taken & (res_target != head_tgt_s)));
    assign flush_tgt_s = res_taken ? res_target : (head_pc_s + 32'd4);

    // Occupancy update; a mispredict empties the queue, dropping a same-cycle push.
    always_comb begin
        count_nxt_s = count_r;
        if (mispred_s) begin
            count_nxt_s = {CNT_W{1'b0}};
        end else begin
            case ({push_fire_s, res_fire_s})
                2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
                2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Entry write port.
    always_ff @(posedge clk) begin
        if (push_fire_s) begin
            pc_mem_r[wr_ptr_r]    <= push_pc;
            tgt_mem_r[wr_ptr_r]   <= push_pred_target;
            hist_mem_r[wr_ptr_r]  <= push_hist;
            taken_mem_r[wr_ptr_r] <= push_pred_taken;
        end
    end

    // Queue control, predictor update, redirect and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r       <= {PTR_W{1'b0}};
            rd_ptr_r       <= {PTR_W{1'b0}};
            count_r        <= {CNT_W{1'b0}};
            brinfo_valid_r <= 1'b0;
            brinfo_pc_r    <= 32'd0;
            brinfo_taken_r <= 1'b0;
            brinfo_hist_r  <= {WIDTH_HIST{1'b0}};
            flush_valid_r  <= 1'b0;
            flush_pc_r     <= 32'd0;
            order_err_r    <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            if (mispred_s) begin
                wr_ptr_r <= {PTR_W{1'b0}};
                rd_ptr_r <= {PTR_W{1'b0}};
            end else begin
                if (push_fire_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
                if (res_fire_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            brinfo_valid_r <= res_fire_s;
            if (res_fire_s) begin
                brinfo_pc_r    <= head_pc_s;
                brinfo_taken_r <= res_taken;
                brinfo_hist_r  <= head_hist_s;
            end
            flush_valid_r <= mispred_s;
            if (mispred_s) flush_pc_r <= flush_tgt_s;
            order_err_r <= order_err_r | (res_fire_s & (res_pc != head_pc_s));
        end
    end

    assign brinfo      = {brinfo_valid_r, brinfo_pc_r, brinfo_taken_r};
    assign brinfo_hist = brinfo_hist_r;
    assign flush_valid = flush_valid_r;
    assign flush_pc    = flush_pc_r;
    assign order_err   = order_err_r;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0] stat_resolved_r;
    logic [31:0] stat_mispred_r;

    // Saturating resolve and mispredict counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resolved_r <= 32'd0;
            stat_mispred_r  <= 32'd0;
        end else begin
            if (res_fire_s && (stat_resolved_r != 32'hFFFF_FFFF))
                stat_resolved_r <= stat_resolved_r + 32'd1;
            if (mispred_s && (stat_mispred_r != 32'hFFFF_FFFF))
                stat_mispred_r <= stat_mispred_r + 32'd1;
        end
    end

    assign stat_resolved = stat_resolved_r;
    assign stat_mispred  = stat_mispred_r;
`else
    assign stat_resolved = 32'd0;
    assign stat_mispred  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// -----------------------------------------------------------------------------
// tb_branch_resolver
//
// Directed self-checking bench for branch_resolver (DEPTH 8, WIDTH_HIST 10).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_branch_resolver;

    logic        clk;
    logic        rst_n;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_pc;
    logic        push_pred_taken;
    logic [31:0] push_pred_target;
    logic [9:0]  push_hist;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic [33:0] brinfo;
    logic [9:0]  brinfo_hist;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic        order_err;
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispred;

    int tests;
    int fails;

    branch_resolver #(.DEPTH(8), .WIDTH_HIST(10)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .push_valid       (push_valid),
        .push_ready       (push_ready),
        .push_pc          (push_pc),
        .push_pred_taken  (push_pred_taken),
        .push_pred_target (push_pred_target),
        .push_hist        (push_hist),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_pc           (res_pc),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .brinfo           (brinfo),
        .brinfo_hist      (brinfo_hist),
        .flush_valid      (flush_valid),
        .flush_pc         (flush_pc),
        .order_err        (order_err),
        .stat_resolved    (stat_resolved),
        .stat_mispred     (stat_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_push(input logic v, input logic [31:0] pc, input logic tk,
                            input logic [31:0] tgt, input logic [9:0] h);
        push_valid       = v;
        push_pc          = pc;
        push_pred_taken  = tk;
        push_pred_target = tgt;
        push_hist        = h;
    endtask

    task automatic set_res(input logic v, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt);
        res_valid  = v;
        res_pc     = pc;
        res_taken  = tk;
        res_target = tgt;
    endtask

    initial begin
        logic [31:0] exp_resolved;
        logic [31:0] exp_mispred;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        set_push(1'b0, 32'd0, 1'b0, 32'd0, 10'd0);
        set_res(1'b0, 32'd0, 1'b0, 32'd0);

        // Reset state
        tick();
        check("rst_res_ready",   64'(res_ready),     64'h0);
        check("rst_push_ready",  64'(push_ready),    64'h1);
        check("rst_brinfo",      64'(brinfo),        64'h0);
        check("rst_flush_valid", 64'(flush_valid),   64'h0);
        check("rst_flush_pc",    64'(flush_pc),      64'h0);
        check("rst_order_err",   64'(order_err),     64'h0);
        check("rst_stat_res",    64'(stat_resolved), 64'h0);
        check("rst_stat_mis",    64'(stat_mispred),  64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Correct taken prediction
        set_push(1'b1, 32'h100, 1'b1, 32'h200, 10'h155);
        tick();
        set_push(1'b0, 32'd0, 1'b0, 32'd0, 10'd0);
        check("t1_res_ready", 64'(res_ready), 64'h1);
        check("t1_brinfo_idle", 64'(brinfo[33]), 64'h0);
        set_res(1'b1, 32'h100, 1'b1, 32'h200);
        tick();
        set_res(1'b0, 32'd0, 1'b0, 32'd0);
        check("t1_brinfo",      64'(brinfo),      {30'd0, 1'b1, 32'h100, 1'b1});
        check("t1_brinfo_hist", 64'(brinfo_hist), 64'h155);
        check("t1_no_flush",    64'(flush_valid), 64'h0);
        check("t1_empty",       64'(res_ready),   64'h0);
        tick();
        check("t1_brinfo_pulse", 64'(brinfo[33]), 64'h0);

        // Predicted not-taken, actually taken; same-cycle push is discarded
        set_push(1'b1, 32'h100, 1'b0, 32'h0, 10'h0AA);
        tick();
        set_push(1'b1, 32'h140, 1'b0, 32'h0, 10'h001);
        set_res(1'b1, 32'h100, 1'b1, 32'h180);
        tick();
        set_push(1'b0, 32'd0, 1'b0, 32'd0, 10'd0);
        set_res(1'b0, 32'd0, 1'b0, 32'd0);
        check("t2_flush_valid", 64'(flush_valid), 64'h1);
        check("t2_flush_pc",    64'(flush_pc),    64'h180);
        check("t2_brinfo",      64'(brinfo),      {30'd0, 1'b1, 32'h100, 1'b1});
        check("t2_empty",       64'(res_ready),   64'h0);
        check("t2_push_block",  64'(push_ready),  64'h0);
        tick();
        check("t2_flush_pulse", 64'(flush_valid), 64'h0);
        check("t2_push_ready",  64'(push_ready),  64'h1);
        check("t2_still_empty", 64'(res_ready),   64'h0);

        // Predicted taken, actually not taken -> pc + 4
        set_push(1'b1, 32'h100, 1'b1, 32'h200, 10'h0);
        tick();
        set_push(1'b0, 32'd0, 1'b0, 32'd0, 10'd0);
        set_res(1'b1, 32'h100, 1'b0, 32'hDEAD);
        tick();
        set_res(1'b0, 32'd0, 1'b0, 32'd0);
        check("t3_flush_valid", 64'(flush_valid), 64'h1);
        check("t3_flush_pc",    64'(flush_pc),    64'h104);
        tick();

        // pc + 4 wraps at 32 bits
        set_push(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h10, 10'h0);
        tick();
        set_push(1'b0, 32'd0, 1'b0, 32'd0, 10'd0);
        set_res(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        tick();
        set_res(1'b0, 32'd0, 1'b0, 32'd0);
        check("t3b_flush_valid", 64'(flush_valid), 64'h1);
        check("t3b_flush_pc",    64'(flush_pc),    64'h0);
        tick();

        // Fill to DEPTH, then exercise ordering across the pointer wrap
        for (int i = 0; i < 8; i++) begin
            check("t4_fill_ready", 64'(push_ready), 64'h1);
            set_push(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 32'h0, 10'(i));
            tick();
        end
        set_push(1'b1, 32'hBAD0, 1'b0, 32'h0, 10'h3AA);
        check("t4_full_push_ready", 64'(push_ready), 64'h0);
        check("t4_full_res_ready",  64'(res_ready),  64'h1);
        // Push presented while full is ignored; resolve E0
        set_res(1'b1, 32'h1000, 1'b0, 32'h0);
        tick();
        check("t4_pop0_pc", 64'(brinfo), {30'd0, 1'b1, 32'h1000, 1'b0});
        check("t4_after_pop_ready", 64'(push_ready), 64'h1);
        // Simultaneous push of E8 and resolve of E1 keeps occupancy at 7
        set_push(1'b1, 32'h1020, 1'b0, 32'h0, 10'd8);
        set_res(1'b1, 32'h1004, 1'b0, 32'h0);
        tick();
        check("t4_pop1_pc", 64'(brinfo), {30'd0, 1'b1, 32'h1004, 1'b0});
        check("t4_sim_ready", 64'(push_ready), 64'h1);
        // One more push must make the queue full again
        set_push(1'b1, 32'h1024, 1'b0, 32'h0, 10'd9);
        set_res(1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        set_push(1'b0, 32'd0, 1'b0, 32'd0, 10'd0);
        check("t4_refull_ready", 64'(push_ready), 64'h0);
        for (int i = 2; i < 10; i++) begin
            set_res(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 32'h0);
            tick();
            check("t4_drain_pc",   64'(brinfo), {30'd0, 1'b1, 32'h1000 + 32'(4 * i), 1'b0});
            check("t4_drain_hist", 64'(brinfo_hist), 64'(i));
            check("t4_drain_noflush", 64'(flush_valid), 64'h0);
        end
        set_res(1'b0, 32'd0, 1'b0, 32'd0);
        check("t4_drained",   64'(res_ready), 64'h0);
        check("t4_order_ok",  64'(order_err), 64'h0);

        // Out-of-order resolve sets the sticky error, pop proceeds
        set_push(1'b1, 32'h100, 1'b0, 32'h0, 10'h3FF);
        tick();
        set_push(1'b0, 32'd0, 1'b0, 32'd0, 10'd0);
        set_res(1'b1, 32'h300, 1'b0, 32'h0);
        tick();
        set_res(1'b0, 32'd0, 1'b0, 32'd0);
        check("t5_order_err",   64'(order_err),   64'h1);
        check("t5_brinfo",      64'(brinfo),      {30'd0, 1'b1, 32'h100, 1'b0});
        check("t5_brinfo_hist", 64'(brinfo_hist), 64'h3FF);
        check("t5_no_flush",    64'(flush_valid), 64'h0);
        tick();
        tick();
        check("t5_order_held", 64'(order_err), 64'h1);
        check("t5_empty",      64'(res_ready), 64'h0);

`ifdef BRANCH_RESOLVER_STATS_EN
        exp_resolved = 32'd15;
        exp_mispred  = 32'd3;
`else
        exp_resolved = 32'd0;
        exp_mispred  = 32'd0;
`endif
        check("stat_resolved", 64'(stat_resolved), 64'(exp_resolved));
        check("stat_mispred",  64'(stat_mispred),  64'(exp_mispred));

        // Reset mid-operation with three entries queued
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, 32'h2000 + 32'(4 * i), 1'b1, 32'h3000, 10'(i));
            tick();
        end
        set_push(1'b0, 32'd0, 1'b0, 32'd0, 10'd0);
        check("t6_loaded", 64'(res_ready), 64'h1);
        set_res(1'b1, 32'h2000, 1'b0, 32'h0);
        rst_n = 1'b0;
        #2;
        check("t6_rst_res_ready", 64'(res_ready),     64'h0);
        check("t6_rst_order_err", 64'(order_err),     64'h0);
        check("t6_rst_brinfo",    64'(brinfo),        64'h0);
        check("t6_rst_flush",     64'(flush_valid),   64'h0);
        check("t6_rst_flush_pc",  64'(flush_pc),      64'h0);
        check("t6_rst_stat_res",  64'(stat_resolved), 64'h0);
        check("t6_rst_stat_mis",  64'(stat_mispred),  64'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_post_res_ready", 64'(res_ready),   64'h0);
            check("t6_post_brinfo",    64'(brinfo[33]),  64'h0);
            check("t6_post_flush",     64'(flush_valid), 64'h0);
        end
        set_res(1'b0, 32'd0, 1'b0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
